// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: synchronize and deglitch, deframe, E0/F0 prefix tracking, code FIFO, held-key vector.
// Define PS2_RX_PARITY_EN to enable odd-parity checking; otherwise the parity bit is ignored.
`timescale 1ns/1ps
module ps2_key_decoder #(
    parameter int FILTER_LEN  = 4,
    parameter int TIMEOUT_CYC = 50000,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          ps2_clk,
    input  logic                          ps2_data,
    output logic                          code_valid,
    output logic [9:0]                    code_data,
    input  logic                          code_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [4:0]                    keys,
    output logic                          err_frame,
    output logic                          err_parity,
    output logic                          err_timeout,
    output logic                          overflow
);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = AW + 1;
    localparam int FCW = $clog2(FILTER_LEN + 1);
    localparam int TCW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, PARITY = 2'd2, STOP = 2'd3} state_t;

    function automatic logic [4:0] key_mask(input logic ext, input logic [7:0] b);
        logic [4:0] m;
        case ({ext, b})
            9'h01D, 9'h175: m = 5'b00001;
            9'h01C, 9'h16B: m = 5'b00010;
            9'h01B, 9'h172: m = 5'b00100;
            9'h023, 9'h174: m = 5'b01000;
            9'h029:         m = 5'b10000;
            default:        m = 5'b00000;
        endcase
        return m;
    endfunction

`ifdef PS2_RX_PARITY_EN
    function automatic logic odd_parity_ok(input logic [7:0] b, input logic p);
        return ^{b, p};
    endfunction
`endif

    logic [1:0]     clk_sync_r, data_sync_r;
    logic           sync_clk_s, data_s;
    logic           filt_r, fall_r;
    logic [FCW-1:0] fcnt_r;
    state_t         state_r, state_s;
    logic [2:0]     bit_cnt_r, bit_cnt_s;
    logic [7:0]     shift_r, shift_s, byte_r;
`ifdef PS2_RX_PARITY_EN
    logic           par_r, par_s;
`endif
    logic [TCW-1:0] to_cnt_r, to_cnt_s;
    logic           done_s, done_r, frame_err_s, parity_err_s, timeout_s;
    logic           ext_r, brk_r;
    logic [4:0]     keys_r, mask_s;
    logic           err_frame_r, err_parity_r, err_timeout_r, overflow_r;
    logic [9:0]     mem_r [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr_r, rd_ptr_r, rd_next_s;
    logic [CW-1:0]  count_r, count_s;
    logic           push_s, pop_s, full_s, wr_en_s, ovf_s, code_valid_r;
    logic [9:0]     push_data_s, head_s, code_data_r;

    assign sync_clk_s = clk_sync_r[1];
    assign data_s     = data_sync_r[1];

    // Two-flop synchronizers; both lines idle high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync_r  <= 2'b11;
            data_sync_r <= 2'b11;
        end else begin
            clk_sync_r  <= {clk_sync_r[0], ps2_clk};
            data_sync_r <= {data_sync_r[0], ps2_data};
        end
    end

    // Clock deglitch: the filtered level follows only after FILTER_LEN differing cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_r <= 1'b1;
            fcnt_r <= {FCW{1'b0}};
            fall_r <= 1'b0;
        end else begin
            fall_r <= filt_r && !sync_clk_s && (fcnt_r == FCW'(FILTER_LEN - 1));
            if (sync_clk_s == filt_r) begin
                fcnt_r <= {FCW{1'b0}};
            end else if (fcnt_r == FCW'(FILTER_LEN - 1)) begin
                filt_r <= sync_clk_s;
                fcnt_r <= {FCW{1'b0}};
            end else begin
                fcnt_r <= fcnt_r + FCW'(1);
            end
        end
    end

    // Deframing next-state logic; a stalled partial frame is abandoned by the timeout.
    always_comb begin
        state_s      = state_r;
        bit_cnt_s    = bit_cnt_r;
        shift_s      = shift_r;
`ifdef PS2_RX_PARITY_EN
        par_s        = par_r;
`endif
        to_cnt_s     = to_cnt_r;
        done_s       = 1'b0;
        frame_err_s  = 1'b0;
        parity_err_s = 1'b0;
        timeout_s    = 1'b0;
        if (state_r != IDLE && !fall_r && to_cnt_r == TCW'(TIMEOUT_CYC - 1)) begin
            timeout_s = 1'b1;
            state_s   = IDLE;
            to_cnt_s  = {TCW{1'b0}};
        end else if (fall_r) begin
            to_cnt_s = {TCW{1'b0}};
            case (state_r)
                IDLE: begin
                    if (!data_s) begin
                        state_s   = DATA;
                        bit_cnt_s = 3'd0;
                    end else begin
                        frame_err_s = 1'b1;
                    end
                end
                DATA: begin
                    shift_s   = {data_s, shift_r[7:1]};
                    bit_cnt_s = bit_cnt_r + 3'd1;
                    state_s   = (bit_cnt_r == 3'd7) ? PARITY : DATA;
                end
                PARITY: begin
`ifdef PS2_RX_PARITY_EN
                    par_s   = data_s;
`endif
                    state_s = STOP;
                end
                STOP: begin
                    state_s = IDLE;
                    if (data_s) begin
`ifdef PS2_RX_PARITY_EN
                        if (odd_parity_ok(shift_r, par_r)) begin
                            done_s = 1'b1;
                        end else begin
                            parity_err_s = 1'b1;
                        end
`else
                        done_s = 1'b1;
`endif
                    end else begin
                        frame_err_s = 1'b1;
                    end
                end
                default: state_s = IDLE;
            endcase
        end else if (state_r != IDLE) begin
            to_cnt_s = to_cnt_r + TCW'(1);
        end else begin
            to_cnt_s = {TCW{1'b0}};
        end
    end

    // Deframer state and error pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= IDLE;
            bit_cnt_r     <= 3'd0;
            shift_r       <= 8'h00;
`ifdef PS2_RX_PARITY_EN
            par_r         <= 1'b0;
`endif
            to_cnt_r      <= {TCW{1'b0}};
            done_r        <= 1'b0;
            byte_r        <= 8'h00;
            err_frame_r   <= 1'b0;
            err_parity_r  <= 1'b0;
            err_timeout_r <= 1'b0;
        end else begin
            state_r       <= state_s;
            bit_cnt_r     <= bit_cnt_s;
            shift_r       <= shift_s;
`ifdef PS2_RX_PARITY_EN
            par_r         <= par_s;
`endif
            to_cnt_r      <= to_cnt_s;
            done_r        <= done_s;
            byte_r        <= done_s ? shift_r : byte_r;
            err_frame_r   <= frame_err_s;
            err_parity_r  <= parity_err_s;
            err_timeout_r <= timeout_s;
        end
    end

    // FIFO and key-vector control for the byte completed last cycle.
    always_comb begin
        push_s      = done_r && (byte_r != 8'hE0) && (byte_r != 8'hF0);
        push_data_s = {ext_r, brk_r, byte_r};
        mask_s      = key_mask(ext_r, byte_r);
        pop_s       = code_valid_r && code_ready;
        full_s      = (count_r == CW'(FIFO_DEPTH));
        wr_en_s     = push_s && (!full_s || pop_s);
        ovf_s       = push_s && full_s && !pop_s;
        rd_next_s   = pop_s ? rd_ptr_r + AW'(1) : rd_ptr_r;
        count_s     = count_r + CW'(wr_en_s) - CW'(pop_s);
        // A write into the slot about to become head only happens when the FIFO drains to empty.
        head_s      = (wr_en_s && (wr_ptr_r == rd_next_s)) ? push_data_s : mem_r[rd_next_s];
    end

    // Prefix flags and held keys; a dropped push still updates keys.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ext_r  <= 1'b0;
            brk_r  <= 1'b0;
            keys_r <= 5'b00000;
        end else begin
            if (timeout_s || parity_err_s) begin
                ext_r <= 1'b0;
                brk_r <= 1'b0;
            end else if (done_r) begin
                ext_r <= (byte_r == 8'hE0) ? 1'b1 : ((byte_r == 8'hF0) ? ext_r : 1'b0);
                brk_r <= (byte_r == 8'hF0) ? 1'b1 : ((byte_r == 8'hE0) ? brk_r : 1'b0);
            end
            if (push_s) begin
                keys_r <= brk_r ? (keys_r & ~mask_s) : (keys_r | mask_s);
            end
        end
    end

    // Code FIFO storage, pointers and registered head.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= 10'h000;
            end
            wr_ptr_r     <= {AW{1'b0}};
            rd_ptr_r     <= {AW{1'b0}};
            count_r      <= {CW{1'b0}};
            code_valid_r <= 1'b0;
            code_data_r  <= 10'h000;
            overflow_r   <= 1'b0;
        end else begin
            if (wr_en_s) begin
                mem_r[wr_ptr_r] <= push_data_s;
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            rd_ptr_r     <= rd_next_s;
            count_r      <= count_s;
            code_valid_r <= (count_s != {CW{1'b0}});
            code_data_r  <= (count_s != {CW{1'b0}}) ? head_s : 10'h000;
            overflow_r   <= ovf_s;
        end
    end

    assign code_valid  = code_valid_r;
    assign code_data   = code_data_r;
    assign fifo_count  = count_r;
    assign keys        = keys_r;
    assign err_frame   = err_frame_r;
    assign err_parity  = err_parity_r;
    assign err_timeout = err_timeout_r;
    assign overflow    = overflow_r;
endmodule
